// File: rtl/keypad_emulator.sv
// Switch side of a 4x4 matrix keypad: shorts the latched key's row to its column while closed.
// Optional contact bounce (LFSR-driven) is built when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator #(
  parameter int          HOLD_W        = 8,
  parameter int          GAP_CYCLES    = 16,
  parameter int          BOUNCE_CYCLES = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        rows,
  output logic [3:0]        cols,
  output logic              pressed,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd4;
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
  localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
`endif

  localparam int PH_W = 16;

  // The done/IDLE cycle is the last released cycle, so the GAP state itself
  // lasts GAP_CYCLES-1 cycles and is skipped entirely when GAP_CYCLES is 1.
  localparam logic [2:0]      GAP_ENTRY = (GAP_CYCLES == 1) ? S_IDLE : S_GAP;
  localparam logic [PH_W-1:0] GAP_LOAD  = PH_W'(GAP_CYCLES - 1);
  localparam logic            GAP_DONE  = (GAP_CYCLES == 1);

  logic [2:0]        state;
  logic [1:0]        row_sel;
  logic [1:0]        col_sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_load;
  logic [PH_W-1:0]   ph_cnt;
  logic              contact;
  logic              accept;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign hold_load = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

`ifdef KEYPAD_BOUNCE_EN
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [7:0] lfsr;
  logic       in_bounce;

  assign in_bounce = (state == S_BOUNCE_IN) || (state == S_BOUNCE_OUT);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; advances only inside a bounce window.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (in_bounce) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, 8'(BOUNCE_CYCLES)};
`endif

  // NOTE: default assignment first so every path drives contact (no latch).
  always_comb begin
    contact = 1'b0;
    case (state)
      S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
      S_BOUNCE_IN,
      S_BOUNCE_OUT: contact = lfsr[0];
`endif
      default:      contact = 1'b0;
    endcase
  end

  assign pressed = contact;
  assign cols    = contact ? ({4{rows[row_sel]}} & (4'b0001 << col_sel)) : 4'b0000;

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      row_sel  <= 2'd0;
      col_sel  <= 2'd0;
      hold_cnt <= '0;
      ph_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            row_sel  <= cmd_key[3:2];
            col_sel  <= cmd_key[1:0];
            hold_cnt <= hold_load;
`ifdef KEYPAD_BOUNCE_EN
            state    <= S_BOUNCE_IN;
            ph_cnt   <= PH_W'(BOUNCE_CYCLES);
`else
            state    <= S_HOLD;
`endif
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        S_BOUNCE_IN: begin
          if (ph_cnt == PH_W'(1)) state  <= S_HOLD;
          else                    ph_cnt <= ph_cnt - PH_W'(1);
        end
`endif
        S_HOLD: begin
          if (hold_cnt == HOLD_W'(1)) begin
`ifdef KEYPAD_BOUNCE_EN
            state  <= S_BOUNCE_OUT;
            ph_cnt <= PH_W'(BOUNCE_CYCLES);
`else
            state  <= GAP_ENTRY;
            ph_cnt <= GAP_LOAD;
            done   <= GAP_DONE;
`endif
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        S_BOUNCE_OUT: begin
          if (ph_cnt == PH_W'(1)) begin
            state  <= GAP_ENTRY;
            ph_cnt <= GAP_LOAD;
            done   <= GAP_DONE;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
`endif
        S_GAP: begin
          if (ph_cnt <= PH_W'(1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt - PH_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator; bounce checks run when KEYPAD_BOUNCE_EN is defined.
module tb_keypad_emulator;

  localparam int HOLD_W = 8;
  localparam int GAP    = 16;
  localparam int BOUNCE = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic [3:0]        rows;
  logic [3:0]        cols;
  logic              pressed;
  logic              done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_W(HOLD_W), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BOUNCE), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .rows(rows), .cols(cols),
    .pressed(pressed), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout waited=%0d done=%b expected=1", name, n, done);
    end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = '0; rows = 4'hF;
    repeat (3) tick();
    checks++;
    if (cols !== 4'b0000 || pressed !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state cols=%b pressed=%b done=%b ready=%b expected 0000/0/0/1",
               cols, pressed, done, cmd_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cols !== 4'b0000 || pressed !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset cols=%b pressed=%b ready=%b expected 0000/0/1",
               cols, pressed, cmd_ready);
    end
  endtask

  task automatic test_single_press;
    logic exp_done;
    cmd_key = 4'h6; cmd_hold = 8'd5; rows = 4'b0010; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cols !== 4'b0100 || pressed !== 1'b1) begin
        failures++;
        $display("FAIL single_hold cyc=%0d cols=%b pressed=%b expected 0100/1", i, cols, pressed);
      end
      tick();
    end
    for (int k = 0; k < GAP; k++) begin
      exp_done = (k == GAP - 1);
      checks++;
      if (cols !== 4'b0000 || done !== exp_done || cmd_ready !== exp_done) begin
        failures++;
        $display("FAIL single_gap cyc=%0d cols=%b done=%b ready=%b expected 0000/%b/%b",
                 k, cols, done, cmd_ready, exp_done, exp_done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_after_done done=%b ready=%b expected 0/1", done, cmd_ready);
    end
  endtask

  task automatic test_row_gating;
    logic [3:0] exp_cols;
    int         leaks = 0;
    cmd_key = 4'h6; cmd_hold = 8'd8; rows = 4'b0001; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rows = 4'b0001 << (i % 4);
      #1;
      exp_cols = ((i % 4) == 1) ? 4'b0100 : 4'b0000;
      checks++;
      if (cols !== exp_cols) begin
        failures++;
        $display("FAIL row_gating cyc=%0d rows=%b cols=%b expected=%b", i, rows, cols, exp_cols);
      end
      tick();
    end
    rows = 4'b0010;
    for (int k = 0; k < GAP; k++) begin
      if (cols !== 4'b0000) leaks++;
      if (k < GAP - 1) tick();
    end
    checks++;
    if (leaks != 0) begin
      failures++;
      $display("FAIL gap_released leaks=%0d expected=0", leaks);
    end
    wait_done("row_gating", 4);
  endtask

  task automatic test_back_to_back;
    int released = 0;
    int done_at  = -1;
    cmd_key = 4'h0; cmd_hold = 8'd0; rows = 4'b0001; cmd_valid = 1'b1;
    tick();
    cmd_key = 4'h3; cmd_hold = 8'd2;
    checks++;
    if (cols !== 4'b0001) begin
      failures++;
      $display("FAIL hold0_closed cols=%b expected=0001", cols);
    end
    tick();
    while (cols === 4'b0000 && released < 40) begin
      if (done === 1'b1) done_at = released;
      tick();
      if (done_at >= 0) cmd_valid = 1'b0;
      released++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (released != GAP) begin
      failures++;
      $display("FAIL b2b_released got=%0d expected=%0d", released, GAP);
    end
    checks++;
    if (done_at != GAP - 1) begin
      failures++;
      $display("FAIL b2b_done_cycle got=%0d expected=%0d", done_at, GAP - 1);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cols !== 4'b1000) begin
        failures++;
        $display("FAIL b2b_second_hold cyc=%0d cols=%b expected=1000", i, cols);
      end
      tick();
    end
    checks++;
    if (cols !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_second_release cols=%b expected=0000", cols);
    end
    wait_done("b2b", GAP + 4);
  endtask

  task automatic test_reset_mid_hold;
    int dones = 0;
    int leaks = 0;
    cmd_key = 4'hF; cmd_hold = 8'd100; rows = 4'b1000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        checks++;
        if (cols !== 4'b1000) begin
          failures++;
          $display("FAIL key_change_ignored cols=%b expected=1000", cols);
        end
      end
      tick();
    end
    checks++;
    if (cols !== 4'b1000 || pressed !== 1'b1) begin
      failures++;
      $display("FAIL mid_hold_closed cols=%b pressed=%b expected 1000/1", cols, pressed);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (cols !== 4'b0000 || pressed !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold cols=%b pressed=%b ready=%b done=%b expected 0000/0/1/0",
               cols, pressed, cmd_ready, done);
    end
    reset = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (done === 1'b1) dones++;
      if (cols !== 4'b0000) leaks++;
      tick();
    end
    checks++;
    if (dones != 0 || leaks != 0) begin
      failures++;
      $display("FAIL dropped_cmd dones=%0d leaks=%0d expected 0/0", dones, leaks);
    end
  endtask

  task automatic test_bounce;
    logic [7:0] m;
    logic       exp_c;
    m = 8'hA5;
    cmd_key = 4'h5; cmd_hold = 8'd3; rows = 4'b0010; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < ((ph == 1) ? 3 : BOUNCE); k++) begin
        exp_c = (ph == 1) ? 1'b1 : m[0];
        checks++;
        if (pressed !== exp_c || cols !== (exp_c ? 4'b0010 : 4'b0000)) begin
          failures++;
          $display("FAIL bounce ph=%0d cyc=%0d pressed=%b cols=%b expected %b", ph, k, pressed, cols, exp_c);
        end
        if (ph != 1) m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        tick();
      end
    end
    wait_done("bounce", GAP + 4);
  endtask

  initial begin
    test_reset();
`ifdef KEYPAD_BOUNCE_EN
    test_bounce();
`else
    test_single_press();
    test_row_gating();
    test_back_to_back();
    test_reset_mid_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
